// File: rtl/decoder_pipe.sv
// Pipelined index decoder (one-hot / thermometer) with valid/ready backpressure.
// Optional range-error flag alongside Z: define DECODER_PIPE_RANGE_CHK_EN.
module decoder_pipe #(
  parameter int NUM_OUT = 32,
  parameter int A_W     = $clog2(NUM_OUT),
  parameter int STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     A,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] Z
`ifdef DECODER_PIPE_RANGE_CHK_EN
  ,
  output logic               err
`endif
);

`ifdef DECODER_PIPE_RANGE_CHK_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif
  localparam int DW = NUM_OUT + ERR_W;

  // Handshake: a stage loads whenever it is empty or its downstream neighbour
  // loads this cycle; input transfers on in_valid && in_ready, output on
  // out_valid && out_ready. Ready ripples combinationally from out_ready.

  logic               in_range;
  logic [NUM_OUT-1:0] dec;
  logic [DW-1:0]      in_data;

  always_comb begin
    in_range = (32'(A) < NUM_OUT);
    dec      = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (in_range) begin
        dec[i] = mode ? (i <= 32'(A)) : (i == 32'(A));
      end
    end
`ifdef DECODER_PIPE_RANGE_CHK_EN
    in_data = {!in_range, dec};
`else
    in_data = dec;
`endif
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_d [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES:0]   up_valid;
  logic [DW-1:0]     up_data [STAGES+1];

  always_comb begin
    logic r;
    r = out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !valid_q[k] || r;
      rdy[k] = r;
    end

    // Index k of the upstream chain feeds stage k: 0 is the decoder input.
    up_valid   = {valid_q, in_valid};
    up_data[0] = in_data;
    for (int k = 0; k < STAGES; k++) begin
      up_data[k+1] = data_q[k];
    end

    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      if (rdy[k]) begin
        valid_d[k] = up_valid[k];
        data_d[k]  = up_data[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign Z         = data_q[STAGES-1][NUM_OUT-1:0];
`ifdef DECODER_PIPE_RANGE_CHK_EN
  assign err       = data_q[STAGES-1][NUM_OUT];
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: a 32-output/2-stage instance and a 20-output/3-stage
// instance, directed tables and sequences plus randomized traffic vs. a model.
module tb_decoder_pipe;
  localparam int N32 = 32;
  localparam int S32 = 2;
  localparam int N20 = 20;
  localparam int S20 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv32 = 1'b0, ir32, mode32 = 1'b0, ov32, or32 = 1'b0, err32;
  logic [4:0]  a32 = '0;
  logic [31:0] z32;

  logic        iv20 = 1'b0, ir20, m20 = 1'b0, ov20, or20 = 1'b0, err20;
  logic [4:0]  a20 = '0;
  logic [19:0] z20;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          got, sent, stall, cnt;
  logic [31:0] one32 = 32'd1;
  logic [19:0] one20 = 20'd1;

  logic [256:0] exp32_q[$];
  logic [256:0] exp20_q[$];

  typedef struct {
    int          a;
    logic        m;
    logic [31:0] z;
  } vec32_t;

  typedef struct {
    int          a;
    logic        m;
    logic [19:0] z;
    logic        e;
  } vec20_t;

  vec32_t t32[7];
  vec20_t t20[5];

  always #5 clk = ~clk;

  decoder_pipe #(.NUM_OUT(N32), .STAGES(S32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .mode(mode32),
    .out_valid(ov32), .out_ready(or32), .Z(z32)
`ifdef DECODER_PIPE_RANGE_CHK_EN
    , .err(err32)
`endif
  );

  decoder_pipe #(.NUM_OUT(N20), .STAGES(S20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(iv20), .in_ready(ir20), .A(a20), .mode(m20),
    .out_valid(ov20), .out_ready(or20), .Z(z20)
`ifdef DECODER_PIPE_RANGE_CHK_EN
    , .err(err20)
`endif
  );

`ifndef DECODER_PIPE_RANGE_CHK_EN
  assign err32 = 1'b0;
  assign err20 = 1'b0;
`endif

  // Reference: one-hot is a single set bit at A, thermometer is 2^(A+1)-1,
  // anything at or beyond n decodes to zero and flags an error.
  function automatic logic [256:0] exp_item(input int a, input logic m, input int n);
    logic [255:0] one;
    logic [255:0] z;
    logic         e;
    one = 256'd1;
    if (a >= n) begin
      z = '0;
      e = 1'b1;
    end else begin
      z = m ? ((one << (a + 1)) - one) : (one << a);
      e = 1'b0;
    end
`ifndef DECODER_PIPE_RANGE_CHK_EN
    e = 1'b0;
`endif
    return {e, z};
  endfunction

  task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    iv32 = 1'b0;
    iv20 = 1'b0;
    or32 = 1'b1;
    or20 = 1'b1;
    repeat (8) step();
  endtask

  // Scoreboards: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp32_q.delete();
    end else begin
      if (ov32 && or32) begin
        if (exp32_q.size() == 0) begin
          n_checks++;
          $display("FAIL out32_unexpected: got Z=%0h expected no output", z32);
        end else chk("mon32", {err32, 224'd0, z32}, exp32_q.pop_front());
      end
      if (iv32 && ir32) exp32_q.push_back(exp_item(int'(a32), mode32, N32));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp20_q.delete();
    end else begin
      if (ov20 && or20) begin
        if (exp20_q.size() == 0) begin
          n_checks++;
          $display("FAIL out20_unexpected: got Z=%0h expected no output", z20);
        end else chk("mon20", {err20, 236'd0, z20}, exp20_q.pop_front());
      end
      if (iv20 && ir20) exp20_q.push_back(exp_item(int'(a20), m20, N20));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    t32[0] = '{4,  1'b1, 32'h0000001F};
    t32[1] = '{31, 1'b1, 32'hFFFFFFFF};
    t32[2] = '{0,  1'b1, 32'h00000001};
    t32[3] = '{0,  1'b0, 32'h00000001};
    t32[4] = '{17, 1'b0, 32'h00020000};
    t32[5] = '{10, 1'b1, 32'h000007FF};
    t32[6] = '{31, 1'b0, 32'h80000000};

    t20[0] = '{19, 1'b0, 20'h80000, 1'b0};
    t20[1] = '{25, 1'b0, 20'h00000, 1'b1};
    t20[2] = '{25, 1'b1, 20'h00000, 1'b1};
    t20[3] = '{19, 1'b1, 20'hFFFFF, 1'b0};
    t20[4] = '{0,  1'b1, 20'h00001, 1'b0};

    // Reset held with a live input pending.
    rst  = 1'b1;
    iv32 = 1'b1;
    a32  = 5'd7;
    or32 = 1'b1;
    or20 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_ov", ov32, 0);
      chk("rst_z", z32, 0);
    end
    rst = 1'b0;
    #1;
    chk("rel_ov", ov32, 0);
    chk("rel_z", z32, 0);
    step();
    chk("rel_ov_edge1", ov32, 0);
    iv32 = 1'b0;
    drain();

    // One-hot sweep: latency 2 edges, then one output per cycle.
    iv32 = 1'b1;
    a32 = 5'd0;
    mode32 = 1'b0;
    or32 = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k < 32) a32 = 5'(k);
      else iv32 = 1'b0;
      if (k == 1 || k == 34) chk("sweep_idle_ov", ov32, 0);
      else begin
        chk("sweep_ov", ov32, 1);
        chk("sweep_z", z32, one32 << (k - 2));
      end
    end
    drain();

    // Table of single items in both modes.
    for (int i = 0; i < 7; i++) begin
      a32 = 5'(t32[i].a);
      mode32 = t32[i].m;
      iv32 = 1'b1;
      step();
      iv32 = 1'b0;
      cnt = 0;
      while (!ov32 && cnt < 10) begin
        step();
        cnt++;
      end
      chk("tbl_ov", ov32, 1);
      chk("tbl_z", z32, t32[i].z);
      step();
    end
    drain();

    // Backpressure: stall while the third item is presented.
    got = 0;
    sent = 0;
    stall = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      if (got == 2 && stall < 5) begin
        or32 = 1'b0;
        stall++;
      end else or32 = 1'b1;
      if (sent < 10) begin
        iv32 = 1'b1;
        a32 = 5'(sent);
      end else iv32 = 1'b0;
      mode32 = 1'b0;
      #1;
      if (!or32) begin
        chk("bp_hold_ov", ov32, 1);
        chk("bp_hold_z", z32, 32'h4);
      end
      if (got >= 2 && sent < 10) chk("bp_ready", ir32, or32);
      if (ov32 && or32) begin
        chk("bp_z", z32, one32 << got);
        got++;
      end
      if (iv32 && ir32) sent++;
      step();
    end
    chk("bp_count", got, 10);
    drain();

    // Non-power-of-two width with out-of-range indices.
    got = 0;
    sent = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (sent < 5) begin
        iv20 = 1'b1;
        a20 = 5'(t20[sent].a);
        m20 = t20[sent].m;
      end else iv20 = 1'b0;
      #1;
      if (ov20) begin
        chk("np_z", z20, t20[got].z);
`ifdef DECODER_PIPE_RANGE_CHK_EN
        chk("np_err", err20, t20[got].e);
`endif
        got++;
      end
      if (iv20 && ir20) sent++;
      step();
    end
    chk("np_count", got, 5);
    chk("np_one_hot_19", t20[0].z, one20 << 19);
    drain();

    // Reset while two items are in flight.
    or32 = 1'b1;
    iv32 = 1'b1;
    a32 = 5'd5;
    mode32 = 1'b0;
    step();
    a32 = 5'd6;
    step();
    iv32 = 1'b0;
    chk("mr_ov_before", ov32, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_ov_async", ov32, 0);
    chk("mr_z_async", z32, 0);
    step();
    rst = 1'b0;
    iv32 = 1'b1;
    a32 = 5'd3;
    step();
    iv32 = 1'b0;
    chk("mr_ov_edge1", ov32, 0);
    step();
    chk("mr_ov_edge2", ov32, 1);
    chk("mr_z_edge2", z32, 32'h8);
    step();
    chk("mr_ov_after", ov32, 0);
    drain();

    // Randomized traffic on both instances; monitors compare with the model.
    for (int c = 0; c < 400; c++) begin
      iv32 = ($urandom_range(0, 3) != 0);
      a32 = 5'($urandom_range(0, 31));
      mode32 = 1'($urandom_range(0, 1));
      or32 = ($urandom_range(0, 9) < 7);
      iv20 = ($urandom_range(0, 3) != 0);
      a20 = 5'($urandom_range(0, 31));
      m20 = 1'($urandom_range(0, 1));
      or20 = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();
    chk("q32_empty", exp32_q.size(), 0);
    chk("q20_empty", exp20_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
